axi4l2core_pipe: RTL

- Next-generation AXI4-Lite slave to core memory-interface (req/gnt/rvalid) bridge.
- Parametrised in address/data width; allows up to MAX_OUTST core transactions in flight, not one at a time.
- Round-robin read/write arbitration; responses buffered in per-channel FIFOs so the single-cycle core_rvalid never needs backpressure.
- Sits between the AXI4-Lite interconnect and a core-side memory/peripheral port.

---
 rtl/axi4l2core_pipe_pkg.sv | 19 +
 rtl/axi4l2core_pipe_fifo.sv | 58 +++++
 rtl/axi4l2core_pipe.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/axi4l2core_pipe_pkg.sv
// Shared types for the AXI4-Lite to core-interface bridge: response codes
// and the read/write direction tag carried through the in-flight FIFO.
package axi4l2core_pipe_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_t;

  function automatic resp_t resp_from_err(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4l2core_pipe_fifo.sv
// Small synchronous FIFO, first-word-fall-through from registers.
// A pop on empty is ignored; a push on full is accepted only alongside a pop.
module axi4l2core_pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/axi4l2core_pipe.sv
// AXI4-Lite slave to core req/gnt/rvalid bridge with up to MAX_OUTST
// transactions in flight, round-robin R/W arbitration and buffered responses.
module axi4l2core_pipe
  import axi4l2core_pipe_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                core_req,
  input  logic                core_gnt,
  output logic                core_we,
  output logic [DATA_W/8-1:0] core_be,
  output logic [ADDR_W-1:0]   core_addr,
  output logic [DATA_W-1:0]   core_wdata,
  input  logic                core_rvalid,
  input  logic [DATA_W-1:0]   core_rdata,
  input  logic                core_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_OUTST + 1);
  localparam int R_W    = DATA_W + 2;

  logic [CNT_W-1:0] r_credit;
  logic             r_lock;
  dir_t             r_lock_dir;
  dir_t             r_last_grant;

  logic             w_rd_cand;
  logic             w_wr_cand;
  dir_t             w_sel_dir;
  logic             w_sel_cand;
  logic             w_issue_ok;
  logic             w_grant;
  logic             w_r_ret;
  logic             w_b_ret;

  logic             w_tag_head;
  logic             w_tag_full;
  logic             w_tag_empty;
  logic             w_tag_pop;
  dir_t             w_rsp_dir;
  logic             w_r_push;
  logic             w_b_push;
  logic [R_W-1:0]   w_r_din;
  logic [R_W-1:0]   w_r_head;
  logic             w_r_full;
  logic             w_r_empty;
  resp_t            w_b_head;
  logic             w_b_full;
  logic             w_b_empty;

  assign w_wr_cand = awvalid && wvalid;
  assign w_rd_cand = arvalid;

  // A stalled request keeps its direction so the core sees stable fields.
  always_comb begin
    w_sel_dir = DIR_READ;
    if (r_lock)
      w_sel_dir = r_lock_dir;
    else if (w_rd_cand && w_wr_cand)
      w_sel_dir = (r_last_grant == DIR_WRITE) ? DIR_READ : DIR_WRITE;
    else if (w_wr_cand)
      w_sel_dir = DIR_WRITE;
  end

  assign w_sel_cand = (w_sel_dir == DIR_READ) ? w_rd_cand : w_wr_cand;
  assign w_issue_ok = (r_credit < CNT_W'(MAX_OUTST)) && !w_tag_full
                      && !w_r_full && !w_b_full;

  assign core_req   = w_issue_ok && w_sel_cand;
  assign core_we    = (w_sel_dir == DIR_WRITE);
  assign core_addr  = (w_sel_dir == DIR_READ) ? araddr : awaddr;
  assign core_be    = (w_sel_dir == DIR_READ) ? {STRB_W{1'b1}} : wstrb;
  assign core_wdata = wdata;

  assign w_grant = core_req && core_gnt;
  assign arready = w_grant && (w_sel_dir == DIR_READ);
  assign awready = w_grant && (w_sel_dir == DIR_WRITE);
  assign wready  = awready;

  assign w_r_ret = rvalid && rready;
  assign w_b_ret = bvalid && bready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_credit     <= '0;
      r_lock       <= 1'b0;
      r_lock_dir   <= DIR_READ;
      r_last_grant <= DIR_WRITE;
    end else begin
      r_credit <= r_credit + CNT_W'(w_grant) - CNT_W'(w_r_ret) - CNT_W'(w_b_ret);
      if (w_grant) begin
        r_lock       <= 1'b0;
        r_last_grant <= w_sel_dir;
      end else if (core_req) begin
        r_lock     <= 1'b1;
        r_lock_dir <= w_sel_dir;
      end
    end
  end

  // Responses come back in grant order; the tag says which channel owns them.
  assign w_tag_pop = core_rvalid && !w_tag_empty;
  assign w_rsp_dir = dir_t'(w_tag_head);
  assign w_r_push  = w_tag_pop && (w_rsp_dir == DIR_READ);
  assign w_b_push  = w_tag_pop && (w_rsp_dir == DIR_WRITE);
  assign w_r_din   = {core_rdata, resp_from_err(core_err)};

  axi4l2core_pipe_fifo #(.WIDTH(1), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_push  (w_grant),
    .i_data  (w_sel_dir),
    .i_pop   (w_tag_pop),
    .o_head  (w_tag_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  axi4l2core_pipe_fifo #(.WIDTH(R_W), .DEPTH(MAX_OUTST)) u_r_fifo (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_push  (w_r_push),
    .i_data  (w_r_din),
    .i_pop   (w_r_ret),
    .o_head  (w_r_head),
    .o_full  (w_r_full),
    .o_empty (w_r_empty)
  );

  axi4l2core_pipe_fifo #(.WIDTH(2), .DEPTH(MAX_OUTST)) u_b_fifo (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_push  (w_b_push),
    .i_data  (resp_from_err(core_err)),
    .i_pop   (w_b_ret),
    .o_head  (w_b_head),
    .o_full  (w_b_full),
    .o_empty (w_b_empty)
  );

  assign rvalid = !w_r_empty;
  assign rdata  = w_r_empty ? '0 : w_r_head[R_W-1:2];
  assign rresp  = w_r_empty ? RESP_OKAY : w_r_head[1:0];
  assign bvalid = !w_b_empty;
  assign bresp  = w_b_empty ? RESP_OKAY : w_b_head;

endmodule
